// File: rtl/mux_2_to_1.sv
// Registered two-input word selector: forwards a or b (chosen by op) into an
// output register on enabled clock edges, with a one-cycle out_valid strobe.
module mux_2_to_1 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  // Handshake: en is a one-sided valid with no ready; every edge with en=1
  // captures op ? b : a, and out_valid pulses for exactly the following cycle.
  logic [WIDTH-1:0] out_d, out_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (en) begin
      out_d       = op ? b : a;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_2_to_1.sv
// Bench for mux_2_to_1: directed vector table, a mid-stream reset sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_mux_2_to_1;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         out_valid;

  int total;
  int bad;

  typedef struct {
    logic         rst_n;
    logic         en;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_out;
    logic         exp_valid;
  } vec_t;

  vec_t vecs[$];
  logic [W-1:0] exp_q[$];

  mux_2_to_1 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .op        (op),
    .a         (a),
    .b         (b),
    .out       (out),
    .out_valid (out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic e, input logic o,
                       input logic [W-1:0] da, input logic [W-1:0] db);
    rst_n = r;
    en    = e;
    op    = o;
    a     = da;
    b     = db;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] exp_out,
                       input logic exp_valid);
    total++;
    if (out !== exp_out || out_valid !== exp_valid) begin
      bad++;
      $display("FAIL %s: got out=%h valid=%b, want out=%h valid=%b",
               name, out, out_valid, exp_out, exp_valid);
    end
  endtask

  task automatic add_vec(input logic r, input logic e, input logic o,
                         input logic [W-1:0] da, input logic [W-1:0] db,
                         input logic [W-1:0] xo, input logic xv);
    vec_t v;
    v.rst_n = r; v.en = e; v.op = o; v.a = da; v.b = db;
    v.exp_out = xo; v.exp_valid = xv;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] edge_word;
    logic [W-1:0] src [2];
    logic [W-1:0] want;
    logic         want_valid;
    logic         r, e, o;
    logic [W-1:0] ra, rb;

    total = 0;
    bad   = 0;
    ones      = '1;
    edge_word = 64'h8000_0000_0000_0001;

    // reset held with a live capture request
    add_vec(1'b0, 1'b1, 1'b1, 64'd55, 64'd27, 64'd0,  1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 64'd55, 64'd27, 64'd0,  1'b0);
    // select b
    add_vec(1'b1, 1'b1, 1'b1, 64'd55, 64'd27, 64'd27, 1'b1);
    add_vec(1'b1, 1'b1, 1'b1, 64'd73, 64'd42, 64'd42, 1'b1);
    // select a and toggle
    add_vec(1'b1, 1'b1, 1'b0, 64'd55, 64'd27, 64'd55, 1'b1);
    add_vec(1'b1, 1'b1, 1'b1, 64'd55, 64'd27, 64'd27, 1'b1);
    add_vec(1'b1, 1'b1, 1'b0, 64'd98, 64'd12, 64'd98, 1'b1);
    // hold with en=0 while inputs wander
    add_vec(1'b1, 1'b0, 1'b1, 64'd1,  64'd2,  64'd98, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 64'd3,  64'd4,  64'd98, 1'b0);
    add_vec(1'b1, 1'b0, 1'b1, ones,   ones,   64'd98, 1'b0);
    // full width
    add_vec(1'b1, 1'b1, 1'b0, ones,   64'd0,  ones,   1'b1);
    add_vec(1'b1, 1'b1, 1'b1, 64'd0,  edge_word, edge_word, 1'b1);

    drive(1'b0, 1'b1, 1'b1, 64'd55, 64'd27);
    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid);
    end

    // reset mid-stream discards the pending capture, then recovery
    drive(1'b1, 1'b1, 1'b1, 64'd55, 64'd27);
    step();
    check("mid_pre", 64'd27, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 64'd55, 64'd27);
    step();
    check("mid_rst", 64'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 64'd5, 64'd27);
    step();
    check("mid_recover", 64'd5, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 64'd9, 64'd9);
    step();
    check("mid_hold", 64'd5, 1'b1 ^ 1'b1);

    // randomized traffic: model keeps the history of captured words
    exp_q.delete();
    exp_q.push_back(64'd5);
    for (int n = 0; n < 300; n++) begin
      r  = ($urandom_range(0, 19) != 0);
      e  = ($urandom_range(0, 3) != 0);
      o  = $urandom_range(0, 1);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      drive(r, e, o, ra, rb);
      src[0] = ra;
      src[1] = rb;
      if (!r) begin
        exp_q.delete();
        want_valid = 1'b0;
      end else if (e) begin
        exp_q.push_back(src[o]);
        want_valid = 1'b1;
      end else begin
        want_valid = 1'b0;
      end
      want = (exp_q.size() == 0) ? '0 : exp_q[$];
      step();
      check($sformatf("rand%0d", n), want, want_valid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
